// File: rtl/fire_mode_icon_renderer_pkg.sv
// Shared HUD definitions: fire-mode encodings, RGB332 palette and icon sprite geometry.
package fire_mode_icon_renderer_pkg;

  localparam int unsigned ICON_W = 48;
  localparam int unsigned ICON_H = 24;

  typedef enum logic [1:0] {
    FM_THREE = 2'd0,
    FM_FIVE  = 2'd1,
    FM_ONE   = 2'd2
  } fire_mode_e;

  localparam logic [7:0] RGB_CLEAR  = 8'h00;
  localparam logic [7:0] RGB_WHITE  = 8'hFF;
  localparam logic [7:0] RGB_YELLOW = 8'hFC;
  localparam logic [7:0] RGB_RED    = 8'hE0;

  // Three-entry rotation; the unused encoding falls back to the first mode.
  function automatic fire_mode_e next_mode(input fire_mode_e m);
    fire_mode_e n;
    unique case (m)
      FM_THREE: n = FM_FIVE;
      FM_FIVE:  n = FM_ONE;
      default:  n = FM_THREE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/icon_addr_gen.sv
// Sprite window compare and registered row-major ROM address for a 48-pixel-wide sprite.
module icon_addr_gen
  import fire_mode_icon_renderer_pkg::*;
#(
  parameter int unsigned IconX = 580,
  parameter int unsigned IconY = 440,
  parameter int unsigned IconW = ICON_W,
  parameter int unsigned IconH = ICON_H
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [9:0]  hcount_i,
  input  logic [9:0]  vcount_i,
  input  logic        video_on_i,
  output logic [10:0] addr_o,
  output logic        in_win_o
);

  localparam logic [10:0] XLo = 11'(IconX);
  localparam logic [10:0] XHi = 11'(IconX + IconW);
  localparam logic [10:0] YLo = 11'(IconY);
  localparam logic [10:0] YHi = 11'(IconY + IconH);

  logic [10:0] h_ext, v_ext;
  logic [5:0]  col;
  logic [4:0]  row;
  logic        in_win;
  logic [10:0] addr_d, addr_q;
  logic        win_q;

  assign h_ext = {1'b0, hcount_i};
  assign v_ext = {1'b0, vcount_i};

  always_comb begin
    in_win = video_on_i && (h_ext >= XLo) && (h_ext < XHi) && (v_ext >= YLo) && (v_ext < YHi);
    col    = 6'(hcount_i - 10'(IconX));
    row    = 5'(vcount_i - 10'(IconY));
    // row*48 as row*32 + row*16; outside the window the address parks at 0.
    addr_d = in_win ? ({1'b0, row, 5'b0} + {2'b0, row, 4'b0} + {5'b0, col}) : 11'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= 11'd0;
      win_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      win_q  <= in_win;
    end
  end

  assign addr_o   = addr_q;
  assign in_win_o = win_q;

endmodule

// File: rtl/fire_mode_icon_renderer.sv
// Fire-mode HUD icon: frame-synchronous mode register, sprite ROM addressing and
// a 3-cycle overlay pipeline matched to the ROM's one-cycle read latency.
module fire_mode_icon_renderer
  import fire_mode_icon_renderer_pkg::*;
#(
  parameter int unsigned IconX = 580,
  parameter int unsigned IconY = 440,
  parameter int unsigned IconW = ICON_W,
  parameter int unsigned IconH = ICON_H
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [9:0]  hcount_i,
  input  logic [9:0]  vcount_i,
  input  logic        video_on_i,
  input  logic        mode_btn_i,
  output logic [1:0]  fire_mode_o,
  output logic [10:0] address_o,
  input  logic [1:0]  pixel_data_i,
  output logic        icon_hit_o,
  output logic [7:0]  rgb_o
);

  fire_mode_e pending_d, pending_q;
  fire_mode_e fire_mode_d, fire_mode_q;
  logic       frame_start;
  logic       win_d1, win_d2_q;
  logic       hit_d, hit_q;
  logic [7:0] rgb_d, rgb_q;

  icon_addr_gen #(
    .IconX(IconX),
    .IconY(IconY),
    .IconW(IconW),
    .IconH(IconH)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .hcount_i  (hcount_i),
    .vcount_i  (vcount_i),
    .video_on_i(video_on_i),
    .addr_o    (address_o),
    .in_win_o  (win_d1)
  );

  assign frame_start = (hcount_i == 10'd0) && (vcount_i == 10'd0);

  // Commit uses the pre-pulse pending value, so a press on the frame-start
  // cycle lands one frame later and the ROM never sees a mode change mid-icon.
  always_comb begin
    pending_d   = mode_btn_i ? next_mode(pending_q) : pending_q;
    fire_mode_d = frame_start ? pending_q : fire_mode_q;
  end

  always_comb begin
    hit_d = 1'b0;
    rgb_d = RGB_CLEAR;
    if (win_d2_q) begin
      unique case (pixel_data_i)
        2'd1: begin hit_d = 1'b1; rgb_d = RGB_WHITE;  end
        2'd2: begin hit_d = 1'b1; rgb_d = RGB_YELLOW; end
        2'd3: begin hit_d = 1'b1; rgb_d = RGB_RED;    end
        default: begin hit_d = 1'b0; rgb_d = RGB_CLEAR; end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q   <= FM_THREE;
      fire_mode_q <= FM_THREE;
      win_d2_q    <= 1'b0;
      hit_q       <= 1'b0;
      rgb_q       <= RGB_CLEAR;
    end else begin
      pending_q   <= pending_d;
      fire_mode_q <= fire_mode_d;
      win_d2_q    <= win_d1;
      hit_q       <= hit_d;
      rgb_q       <= rgb_d;
    end
  end

  assign fire_mode_o = fire_mode_q;
  assign icon_hit_o  = hit_q;
  assign rgb_o       = rgb_q;

endmodule

// File: doc/fire_mode_icon_renderer.md
# fire_mode_icon_renderer

- Sits directly upstream and downstream of `fire_mode_memory` in the HUD path.
- Holds the player's current fire mode and changes it only on frame boundaries.
- Turns the VGA scan position into a sprite-ROM address, then maps the returned 2-bit pixel code to an RGB332 overlay pixel.
- Pipelines a window flag so the overlay lines up with the ROM's one-cycle read latency; the result goes to the top-level colour mux.

## Interface
Parameters:
- `ICON_X`, default 580: left column of the icon window.
- `ICON_Y`, default 440: top row of the icon window.
- `ICON_W`, default 48: icon width in pixels. Fixed by the ROM layout.
- `ICON_H`, default 24: icon height in pixels. 48×24 = 1152 ROM words.

Ports:
- `clk`  in  1: pixel clock. Single clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `hcount`  in  10: current scan column.
- `vcount`  in  10: current scan row.
- `video_on`  in  1: high in the active display area.
- `mode_btn`  in  1: one-cycle pulse that requests the next fire mode. Arrives already debounced and synchronised.
- `fire_mode`  out  2: committed mode; drives the ROM's `fire_mode` input.
- `address`  out  11: registered ROM address.
- `pixel_data`  in  2: ROM output, valid one cycle after `address`.
- `icon_hit`  out  1: high when `rgb` is an opaque icon pixel.
- `rgb`  out  8: overlay colour, RGB332.

## Operation
Mode register:
- `pending_mode` cycles 0→1→2→0 on each `mode_btn` pulse. Value 3 is never produced.
- `fire_mode` loads `pending_mode` in the cycle where `hcount==0 && vcount==0`.
- A `mode_btn` pulse in that same cycle updates `pending_mode` only. It reaches `fire_mode` at the next frame start.

Address generation (stage 1, registered):
- `in_win` = `video_on` && `ICON_X` ≤ `hcount` < `ICON_X+ICON_W` && `ICON_Y` ≤ `vcount` < `ICON_Y+ICON_H`.
- Local coordinates: `col = hcount-ICON_X` (6 bits), `row = vcount-ICON_Y` (5 bits).
- `address = row*48 + col`, computed as `(row<<5)+(row<<4)+col` with an 11-bit result. Maximum value is 1151.
- When `in_win` is low, `address` holds 0.

Alignment (stages 2 and 3):
- `in_win` is delayed two registers, giving `win_d2`, which is aligned with `pixel_data`.

Colour map (stage 3, registered):
- If `win_d2`: code 0 → `icon_hit=0`, `rgb=0` (transparent); 1 → `8'hFF` (white); 2 → `8'hFC` (yellow); 3 → `8'hE0` (red). `icon_hit=1` for codes 1–3.
- If not `win_d2`: `icon_hit=0`, `rgb=0`.

Reset values (all outputs and state):
- `pending_mode=0`, `fire_mode=0`, `address=0`, `icon_hit=0`, `rgb=0`.
- Both window-delay flags clear to 0.
- Reset mid-frame: the overlay is suppressed until window flags propagate again. The mode returns to 0 immediately, without waiting for a frame boundary.

## Timing
- Scan position presented in cycle N → `address` valid at N+1 → `pixel_data` valid at N+2 → `icon_hit`/`rgb` valid at N+3.
- Fixed latency of 3 cycles. The top level delays its background colour by 3 to match.
- `fire_mode` changes only at frame start (plus reset). It is never mid-icon, so no ROM read uses a mixed mode.
- `fire_mode` updates one cycle after the frame-start cycle.
- Back-to-back `mode_btn` pulses in consecutive cycles each advance `pending_mode`.
- Icon edges: the first column at `hcount=ICON_X` and the last at `ICON_X+47` are both rendered. `ICON_X+48` is outside.
- Wrap-around at the right or bottom edge of the icon produces no out-of-range address.

## Structure
Shared HUD package holds:
- Fire-mode encodings: `FM_THREE=0`, `FM_FIVE=1`, `FM_ONE=2`.
- RGB332 palette constants for the colour map.
- Icon dimension constants `ICON_W` and `ICON_H`.

One natural sub-module:
- `icon_addr_gen`: window compare plus the shift-add address, stage 1 only.
- Reusable for other HUD sprites.

## Test plan
- Reset with `rst_n=0` mid-frame → `fire_mode=0`, `address=0`, `icon_hit=0`, `rgb=0` immediately; overlay suppressed until the window flags refill after release.
- Scan `hcount=ICON_X+5`, `vcount=ICON_Y+2` → `address=101` one cycle later. ROM returns code 2 → `rgb=8'hFC`, `icon_hit=1` exactly 3 cycles after the scan position.
- Scan the window corners `(ICON_X,ICON_Y)` → 0 and `(ICON_X+47,ICON_Y+23)` → 1151; `(ICON_X+48,ICON_Y)` → `address` holds 0 and `icon_hit=0`.
- Three `mode_btn` pulses mid-frame → `fire_mode` stays 0 until frame start, then becomes 0 (wrapped: 0→1→2→0). A single pulse instead gives `fire_mode=1` one cycle after `hcount=vcount=0`.
- `mode_btn` asserted exactly at frame start → `fire_mode` keeps its old value this frame and takes the new value at the next frame start.
- ROM code 0 inside the window → `icon_hit=0`, `rgb=0`. `video_on=0` inside the coordinate range → no hit and `address=0`.
